// File: rtl/oclib_bc_serial_link.sv
// oclib_bc_serial_link
// Bidirectional serial byte-channel link: a ready/valid word interface on the
// local side and a 2-wire toggle protocol with a 1-wire ack on the link side.
// The TX path buffers words in a small FIFO and sends them one bit at a time.
// Only one toggle is in flight at any moment.
// The RX path synchronises the peer's toggle lines and reassembles words.
// When the output register is still occupied, it stalls the peer by leaving
// the final bit of a word un-acked.
// Optional feature: define OC_BC_SERIAL_LINK_PARITY_EN to append an even-parity
// bit to every word on TX and check it on RX.

module oclib_bc_serial_link #(
  parameter int Width      = 8,
  parameter int FifoDepth  = 4,
  parameter int SyncCycles = 2,
  parameter int MsbFirst   = 1
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic [Width-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [1:0]       tx_wire,
  input  logic             tx_ack,
  input  logic [1:0]       rx_wire,
  output logic             rx_ack,
  output logic [Width-1:0] rx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic             rx_error
);

`ifdef OC_BC_SERIAL_LINK_PARITY_EN
  localparam int FrameBits = Width + 1;
`else
  localparam int FrameBits = Width;
`endif
  localparam int AddrW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
  localparam int CntW  = $clog2(FrameBits + 1);

  localparam logic [AddrW:0]  PtrOne    = 1;
  localparam logic [CntW-1:0] CntOne    = 1;
  localparam logic [CntW-1:0] CntFrame  = CntW'(FrameBits);
  localparam logic [CntW-1:0] CntLast   = CntW'(FrameBits - 1);

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_LOAD,
    TX_SEND,
    TX_WAIT
  } tx_state_t;

  // Reverses bit order so the shift register can always send from its top bit.
  function automatic logic [Width-1:0] bit_reverse(input logic [Width-1:0] d);
    logic [Width-1:0] r;
    r = '0;
    for (int i = 0; i < Width; i++) begin
      r[i] = d[Width-1-i];
    end
    return r;
  endfunction

  // Builds the on-wire frame in send order, first bit in the MSB position.
  function automatic logic [FrameBits-1:0] tx_frame(input logic [Width-1:0] d);
    logic [Width-1:0] ordered;
    ordered = (MsbFirst != 0) ? d : bit_reverse(d);
`ifdef OC_BC_SERIAL_LINK_PARITY_EN
    return {ordered, ^d};
`else
    return ordered;
`endif
  endfunction

  // Shifts one received data bit into the assembly register in link order.
  function automatic logic [Width-1:0] rx_shift_in(input logic [Width-1:0] cur,
                                                   input logic b);
    logic [Width-1:0] t;
    if (MsbFirst != 0) begin
      t = cur << 1;
      t[0] = b;
    end else begin
      t = cur >> 1;
      t[Width-1] = b;
    end
    return t;
  endfunction

  // ---------------------------------------------------------------------------
  // TX FIFO
  // ---------------------------------------------------------------------------
  logic [Width-1:0] fifo_mem [FifoDepth];
  logic [AddrW:0]   wr_ptr;
  logic [AddrW:0]   rd_ptr;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_push;
  logic             ready_en;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AddrW] != rd_ptr[AddrW]) &&
                      (wr_ptr[AddrW-1:0] == rd_ptr[AddrW-1:0]);
  assign tx_ready   = ready_en & ~fifo_full;
  assign fifo_push  = tx_valid & tx_ready;

  // Write pointer and the ready enable that holds tx_ready low during reset.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      ready_en <= 1'b0;
      wr_ptr   <= '0;
    end else begin
      ready_en <= 1'b1;
      if (fifo_push) begin
        wr_ptr <= wr_ptr + PtrOne;
      end
    end
  end

  // FIFO storage; contents are meaningless until the pointers say otherwise.
  always_ff @(posedge clock) begin
    if (fifo_push) begin
      fifo_mem[wr_ptr[AddrW-1:0]] <= tx_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Synchronisers for the asynchronous link inputs
  // ---------------------------------------------------------------------------
  logic [SyncCycles-1:0]      ack_sync;
  logic [SyncCycles-1:0][1:0] rx_sync;
  logic                       ack_cur;
  logic [1:0]                 rx_cur;

  assign ack_cur = ack_sync[SyncCycles-1];
  assign rx_cur  = rx_sync[SyncCycles-1];

  // Multi-flop synchronisation of tx_ack and both rx_wire lines.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      ack_sync <= '0;
      rx_sync  <= '0;
    end else begin
      ack_sync <= {ack_sync[SyncCycles-2:0], tx_ack};
      rx_sync  <= {rx_sync[SyncCycles-2:0], rx_wire};
    end
  end

  // ---------------------------------------------------------------------------
  // TX state machine
  // ---------------------------------------------------------------------------
  tx_state_t            tx_state;
  logic [FrameBits-1:0] tx_shift;
  logic [CntW-1:0]      bitcnt;

  // Pops words, toggles one line per bit and waits for the peer's ack to match.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      tx_state <= TX_IDLE;
      tx_wire  <= 2'b00;
      tx_shift <= '0;
      bitcnt   <= '0;
      rd_ptr   <= '0;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          if (!fifo_empty) begin
            tx_state <= TX_LOAD;
          end
        end
        TX_LOAD: begin
          tx_shift <= tx_frame(fifo_mem[rd_ptr[AddrW-1:0]]);
          rd_ptr   <= rd_ptr + PtrOne;
          bitcnt   <= CntFrame;
          tx_state <= TX_SEND;
        end
        TX_SEND: begin
          if (tx_shift[FrameBits-1]) begin
            tx_wire[1] <= ~tx_wire[1];
          end else begin
            tx_wire[0] <= ~tx_wire[0];
          end
          tx_shift <= tx_shift << 1;
          tx_state <= TX_WAIT;
        end
        TX_WAIT: begin
          if (ack_cur == (tx_wire[0] ^ tx_wire[1])) begin
            bitcnt <= bitcnt - CntOne;
            if (bitcnt != CntOne) begin
              tx_state <= TX_SEND;
            end else if (!fifo_empty) begin
              tx_state <= TX_LOAD;
            end else begin
              tx_state <= TX_IDLE;
            end
          end
        end
        default: begin
          tx_state <= TX_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // RX path
  // ---------------------------------------------------------------------------
  logic [1:0]       rx_seen;
  logic [1:0]       rx_diff;
  logic             rx_one;
  logic             rx_both;
  logic             rx_bit;
  logic             rx_last;
  logic             out_free;
  logic [CntW-1:0]  rx_cnt;
  logic [Width-1:0] rx_shift;
  logic [Width-1:0] rx_shift_next;

  assign rx_diff       = rx_cur ^ rx_seen;
  assign rx_one        = (rx_diff == 2'b01) || (rx_diff == 2'b10);
  assign rx_both       = (rx_diff == 2'b11);
  assign rx_bit        = rx_diff[1];
  assign rx_last       = (rx_cnt == CntLast);
  assign out_free      = ~rx_valid | rx_ready;
  assign rx_shift_next = rx_shift_in(rx_shift, rx_bit);

  // Accepts line changes against the last acked state.
  // A held final bit stays pending until the output register frees up.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      rx_seen  <= 2'b00;
      rx_cnt   <= '0;
      rx_shift <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      rx_error <= 1'b0;
      rx_ack   <= 1'b0;
    end else begin
      rx_ack <= rx_seen[0] ^ rx_seen[1];
      if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
      if (rx_both) begin
        rx_error <= 1'b1;
        rx_seen  <= rx_cur;
      end else if (rx_one) begin
        if (!rx_last) begin
          rx_shift <= rx_shift_next;
          rx_cnt   <= rx_cnt + CntOne;
          rx_seen  <= rx_cur;
        end else begin
`ifdef OC_BC_SERIAL_LINK_PARITY_EN
          if (rx_bit != (^rx_shift)) begin
            rx_error <= 1'b1;
            rx_seen  <= rx_cur;
            rx_cnt   <= '0;
          end else if (out_free) begin
            rx_data  <= rx_shift;
            rx_valid <= 1'b1;
            rx_seen  <= rx_cur;
            rx_cnt   <= '0;
          end
`else
          if (out_free) begin
            rx_data  <= rx_shift_next;
            rx_valid <= 1'b1;
            rx_shift <= rx_shift_next;
            rx_seen  <= rx_cur;
            rx_cnt   <= '0;
          end
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_oclib_bc_serial_link.sv
// tb_oclib_bc_serial_link
// Directed bench for oclib_bc_serial_link (Width=8, MSB first).
// Covers loopback word vectors, TX backpressure, RX backpressure, double-toggle
// errors, bit order on both directions and reset in the middle of a word.
// Honours OC_BC_SERIAL_LINK_PARITY_EN when it is defined for the build.

module tb_oclib_bc_serial_link;

  localparam int Width = 8;
`ifdef OC_BC_SERIAL_LINK_PARITY_EN
  localparam int ParityEn = 1;
`else
  localparam int ParityEn = 0;
`endif
  localparam int FrameBits = Width + ParityEn;

  logic             clock = 1'b0;
  logic             resetn;
  logic [Width-1:0] tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic [1:0]       tx_wire;
  logic             tx_ack;
  logic [1:0]       rx_wire;
  logic             rx_ack;
  logic [Width-1:0] rx_data;
  logic             rx_valid;
  logic             rx_ready;
  logic             rx_error;

  logic             loop_en;
  logic [1:0]       rx_wire_drv;
  logic             tx_ack_drv;

  assign rx_wire = loop_en ? tx_wire : rx_wire_drv;
  assign tx_ack  = loop_en ? rx_ack : tx_ack_drv;

  oclib_bc_serial_link #(
    .Width(Width),
    .FifoDepth(4),
    .SyncCycles(2),
    .MsbFirst(1)
  ) dut (
    .clock(clock),
    .resetn(resetn),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .tx_wire(tx_wire),
    .tx_ack(tx_ack),
    .rx_wire(rx_wire),
    .rx_ack(rx_ack),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .rx_ready(rx_ready),
    .rx_error(rx_error)
  );

  always #5 clock = ~clock;

  int         tog0 = 0;
  int         tog1 = 0;
  logic [1:0] tw_prev = 2'b00;

  // Counts toggles on each tx_wire line as observed by a passive monitor.
  always @(posedge clock) begin
    tw_prev <= tx_wire;
    tog0    <= tog0 + ((tx_wire[0] != tw_prev[0]) ? 1 : 0);
    tog1    <= tog1 + ((tx_wire[1] != tw_prev[1]) ? 1 : 0);
  end

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] data;
    logic [7:0] exp_rx;
    int         exp_ones;
  } vec_t;

  vec_t vecs[6];

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic check_output(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    resetn      = 1'b0;
    tx_valid    = 1'b0;
    rx_wire_drv = 2'b00;
    tx_ack_drv  = 1'b0;
    tick(3);
    resetn = 1'b1;
    tick(1);
  endtask

  task automatic apply_stimulus(input logic [7:0] w, input int budget, output bit ok);
    ok       = 1'b0;
    tx_data  = w;
    tx_valid = 1'b1;
    for (int i = 0; i < budget; i++) begin
      if (tx_ready) begin
        ok = 1'b1;
        break;
      end
      tick(1);
    end
    if (ok) tick(1);
    tx_valid = 1'b0;
  endtask

  task automatic wait_rx_valid(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (rx_valid) begin
        seen = 1'b1;
        break;
      end
      tick(1);
    end
  endtask

  function automatic logic [8:0] frame_bits(input logic [7:0] d, input logic par);
    if (ParityEn != 0) return {d, par};
    return {1'b0, d};
  endfunction

  task automatic peer_send_word(input logic [8:0] bits, input int nbits, output bit ok);
    bit acked;
    ok = 1'b1;
    for (int k = nbits - 1; k >= 0; k--) begin
      if (bits[k]) rx_wire_drv[1] = ~rx_wire_drv[1];
      else         rx_wire_drv[0] = ~rx_wire_drv[0];
      acked = 1'b0;
      for (int i = 0; i < 30; i++) begin
        tick(1);
        if (rx_ack == (rx_wire_drv[0] ^ rx_wire_drv[1])) begin
          acked = 1'b1;
          break;
        end
      end
      if (!acked) ok = 1'b0;
    end
  endtask

  task automatic peer_recv_word(input int nbits, output logic [8:0] word, output bit ok);
    logic [1:0] last;
    logic [1:0] diff;
    bit         seen;
    word = '0;
    ok   = 1'b1;
    last = tx_wire;
    for (int k = 0; k < nbits; k++) begin
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
        tick(1);
        if (tx_wire != last) begin
          seen = 1'b1;
          break;
        end
      end
      if (!seen) begin
        ok = 1'b0;
        break;
      end
      diff       = tx_wire ^ last;
      word       = {word[7:0], diff[1]};
      last       = tx_wire;
      tx_ack_drv = tx_wire[0] ^ tx_wire[1];
    end
  endtask

  // Global time limit so a stuck handshake can never hang the run.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit         ok;
    bit         seen;
    int         b0;
    int         b1;
    int         exp0;
    int         exp1;
    int         tot;
    int         accepted;
    int         n;
    logic [7:0] got[3];
    logic [8:0] word;

    vecs[0] = '{8'hA5, 8'hA5, 4};
    vecs[1] = '{8'h3C, 8'h3C, 4};
    vecs[2] = '{8'hFF, 8'hFF, 8};
    vecs[3] = '{8'h00, 8'h00, 0};
    vecs[4] = '{8'h81, 8'h81, 2};
    vecs[5] = '{8'h07, 8'h07, 3};

    resetn      = 1'b0;
    tx_data     = '0;
    tx_valid    = 1'b0;
    rx_ready    = 1'b1;
    loop_en     = 1'b1;
    rx_wire_drv = 2'b00;
    tx_ack_drv  = 1'b0;

    // Reset values
    tick(1);
    check_output("rst_tx_wire", 32'(tx_wire), 32'h0);
    check_output("rst_tx_ready", 32'(tx_ready), 32'h0);
    check_output("rst_rx_ack", 32'(rx_ack), 32'h0);
    check_output("rst_rx_data", 32'(rx_data), 32'h0);
    check_output("rst_rx_valid", 32'(rx_valid), 32'h0);
    check_output("rst_rx_error", 32'(rx_error), 32'h0);
    tick(2);
    resetn = 1'b1;
    tick(1);
    check_output("post_rst_tx_ready", 32'(tx_ready), 32'h1);

    // Loopback vector table
    tot = 0;
    for (int v = 0; v < 6; v++) begin
      b0 = tog0;
      b1 = tog1;
      apply_stimulus(vecs[v].data, 10, ok);
      check_output($sformatf("loop_push_%0d", v), 32'(ok), 32'h1);
      wait_rx_valid(400, seen);
      check_output($sformatf("loop_rx_seen_%0d", v), 32'(seen), 32'h1);
      check_output($sformatf("loop_rx_data_%0d", v), 32'(rx_data), 32'(vecs[v].exp_rx));
      exp1 = vecs[v].exp_ones + (((ParityEn != 0) && (vecs[v].exp_ones % 2 == 1)) ? 1 : 0);
      exp0 = (Width - vecs[v].exp_ones) + (((ParityEn != 0) && (vecs[v].exp_ones % 2 == 0)) ? 1 : 0);
      check_output($sformatf("loop_tog1_%0d", v), 32'(tog1 - b1), 32'(exp1));
      check_output($sformatf("loop_tog0_%0d", v), 32'(tog0 - b0), 32'(exp0));
      if (v < 2) tot += (tog0 - b0) + (tog1 - b1);
      tick(1);
    end
    check_output("loop_first_two_toggles", 32'(tot), 32'(16 + 2 * ParityEn));
    check_output("loop_rx_error", 32'(rx_error), 32'h0);

    // TX backpressure with the ack held constant
    loop_en = 1'b0;
    do_reset();
    b0 = tog0 + tog1;
    accepted = 0;
    for (int k = 0; k < 6; k++) begin
      apply_stimulus((k == 0) ? 8'h80 : 8'(k), 3, ok);
      if (ok) accepted++;
    end
    check_output("hold_accepted", 32'(accepted), 32'd5);
    check_output("hold_tx_ready", 32'(tx_ready), 32'h0);
    tick(20);
    check_output("hold_toggles", 32'(tog0 + tog1 - b0), 32'd1);
    check_output("hold_tx_wire", 32'(tx_wire), 32'h2);

    // RX backpressure in loopback
    loop_en  = 1'b1;
    rx_ready = 1'b0;
    do_reset();
    b0 = tog0 + tog1;
    apply_stimulus(8'h11, 10, ok);
    apply_stimulus(8'h22, 10, ok);
    apply_stimulus(8'h33, 10, ok);
    tick(600);
    check_output("bp_rx_valid", 32'(rx_valid), 32'h1);
    check_output("bp_rx_data", 32'(rx_data), 32'h11);
    check_output("bp_unacked", 32'(rx_ack ^ tx_wire[0] ^ tx_wire[1]), 32'h1);
    check_output("bp_toggles", 32'(tog0 + tog1 - b0), 32'(16 + 2 * ParityEn));
    rx_ready = 1'b1;
    n = 0;
    for (int i = 0; i < 900; i++) begin
      if (rx_valid) begin
        got[n] = rx_data;
        n++;
        if (n == 3) break;
      end
      tick(1);
    end
    check_output("bp_count", 32'(n), 32'd3);
    check_output("bp_word1", 32'(got[0]), 32'h11);
    check_output("bp_word2", 32'(got[1]), 32'h22);
    check_output("bp_word3", 32'(got[2]), 32'h33);
    tick(300);
    check_output("bp_no_extra", 32'(rx_valid), 32'h0);

    // Both lines toggling together
    loop_en = 1'b0;
    do_reset();
    rx_wire_drv = 2'b11;
    tick(6);
    check_output("dbl_rx_error", 32'(rx_error), 32'h1);
    check_output("dbl_rx_valid", 32'(rx_valid), 32'h0);
    tick(20);
    check_output("dbl_sticky", 32'(rx_error), 32'h1);
    resetn      = 1'b0;
    rx_wire_drv = 2'b00;
    tick(1);
    check_output("dbl_cleared", 32'(rx_error), 32'h0);
    tick(2);
    resetn = 1'b1;
    tick(1);

    // Hand-driven RX word, MSB first
    rx_ready = 1'b0;
    peer_send_word(frame_bits(8'h96, 1'b0), FrameBits, ok);
    check_output("man_rx_acked", 32'(ok), 32'h1);
    check_output("man_rx_valid", 32'(rx_valid), 32'h1);
    check_output("man_rx_data", 32'(rx_data), 32'h96);
    check_output("man_rx_error", 32'(rx_error), 32'h0);
    rx_ready = 1'b1;
    tick(1);
    check_output("man_rx_drain", 32'(rx_valid), 32'h0);

    // Hand-received TX word, bit order on the wire
    do_reset();
    apply_stimulus(8'hC2, 10, ok);
    peer_recv_word(FrameBits, word, ok);
    check_output("man_tx_bits", 32'(ok), 32'h1);
    check_output("man_tx_word", 32'(word), (ParityEn != 0) ? 32'h185 : 32'h0C2);

`ifdef OC_BC_SERIAL_LINK_PARITY_EN
    // Parity error followed by a good word
    do_reset();
    rx_ready = 1'b0;
    peer_send_word(frame_bits(8'h01, 1'b0), FrameBits, ok);
    check_output("par_bad_acked", 32'(ok), 32'h1);
    check_output("par_bad_valid", 32'(rx_valid), 32'h0);
    check_output("par_bad_error", 32'(rx_error), 32'h1);
    peer_send_word(frame_bits(8'h02, 1'b1), FrameBits, ok);
    check_output("par_good_valid", 32'(rx_valid), 32'h1);
    check_output("par_good_data", 32'(rx_data), 32'h02);
    rx_ready = 1'b1;
    tick(1);
`endif

    // Reset in the middle of a word, then a clean word
    loop_en  = 1'b1;
    rx_ready = 1'b1;
    do_reset();
    b0 = tog0 + tog1;
    apply_stimulus(8'hFF, 10, ok);
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (tog0 + tog1 - b0 >= 3) begin
        seen = 1'b1;
        break;
      end
      tick(1);
    end
    check_output("mid_three_bits", 32'(seen), 32'h1);
    resetn = 1'b0;
    tick(1);
    check_output("mid_rst_tx_wire", 32'(tx_wire), 32'h0);
    check_output("mid_rst_tx_ready", 32'(tx_ready), 32'h0);
    check_output("mid_rst_rx_ack", 32'(rx_ack), 32'h0);
    check_output("mid_rst_rx_valid", 32'(rx_valid), 32'h0);
    check_output("mid_rst_rx_data", 32'(rx_data), 32'h0);
    check_output("mid_rst_rx_error", 32'(rx_error), 32'h0);
    tick(2);
    resetn = 1'b1;
    tick(1);
    apply_stimulus(8'h5A, 10, ok);
    wait_rx_valid(400, seen);
    check_output("mid_after_seen", 32'(seen), 32'h1);
    check_output("mid_after_data", 32'(rx_data), 32'h5A);
    check_output("mid_after_error", 32'(rx_error), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
